// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : Eight WIDTH-bit datapath registers (R1..R4, T1..T4) with a
//               shared clear/load/decrement/increment function code and two
//               combinational 8:1 read ports. Define RF_SATURATE_EN to make
//               increment/decrement saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================

module register_file_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [1:0]       i_funsel,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);

    localparam logic [1:0]       c_FUN_CLR  = 2'b00;
    localparam logic [1:0]       c_FUN_LOAD = 2'b01;
    localparam logic [1:0]       c_FUN_DEC  = 2'b10;
    localparam logic [WIDTH-1:0] c_ZERO     = '0;
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_next;

`ifdef RF_SATURATE_EN
    // Hold at the rails instead of wrapping around.
    assign w_inc = (r_q == ~c_ZERO) ? r_q : r_q + c_ONE;
    assign w_dec = (r_q == c_ZERO)  ? r_q : r_q - c_ONE;
`else
    assign w_inc = r_q + c_ONE;
    assign w_dec = r_q - c_ONE;
`endif

    always_comb begin
        w_next = r_q;
        case (i_funsel)
            c_FUN_CLR:  w_next = c_ZERO;
            c_FUN_LOAD: w_next = i_data;
            c_FUN_DEC:  w_next = w_dec;
            default:    w_next = w_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= c_ZERO;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

module register_file #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       O1Sel,
    input  logic [2:0]       O2Sel,
    input  logic [1:0]       FunSel,
    input  logic [3:0]       RSel,
    input  logic [3:0]       TSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2
);

    // Storage is ordered T1..T4, R1..R4 so the read select indexes it directly.
    logic [7:0]       w_en;
    logic [WIDTH-1:0] w_q [8];

    assign w_en = {RSel[0], RSel[1], RSel[2], RSel[3],
                   TSel[0], TSel[1], TSel[2], TSel[3]};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_regs
            register_file_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk      (clock),
                .rst_n    (reset_n),
                .i_en     (w_en[gi]),
                .i_funsel (FunSel),
                .i_data   (I),
                .o_q      (w_q[gi])
            );
        end
    endgenerate

    assign O1 = w_q[O1Sel];
    assign O2 = w_q[O2Sel];

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file, including the
//               RF_SATURATE_EN wrap/saturate variants.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_register_file;

    logic       clock;
    logic       clk_en;
    logic       reset_n;
    logic [2:0] O1Sel;
    logic [2:0] O2Sel;
    logic [1:0] FunSel;
    logic [3:0] RSel;
    logic [3:0] TSel;
    logic [7:0] I;
    logic [7:0] O1;
    logic [7:0] O2;

    int vectors;
    int miscompares;

`ifdef RF_SATURATE_EN
    localparam logic [7:0] c_EXP_INC_FF = 8'hFF;
    localparam logic [7:0] c_EXP_DEC_00 = 8'h00;
`else
    localparam logic [7:0] c_EXP_INC_FF = 8'h00;
    localparam logic [7:0] c_EXP_DEC_00 = 8'hFF;
`endif

    register_file #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .O1Sel   (O1Sel),
        .O2Sel   (O2Sel),
        .FunSel  (FunSel),
        .RSel    (RSel),
        .TSel    (TSel),
        .I       (I),
        .O1      (O1),
        .O2      (O2)
    );

    always begin
        #5;
        if (clk_en) clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Select one register by read-port index (0..3 = T1..T4, 4..7 = R1..R4).
    task automatic load_one(input int idx, input logic [7:0] val);
        @(negedge clock);
        FunSel = 2'b01;
        I      = val;
        RSel   = (idx >= 4) ? (4'b1000 >> (idx - 4)) : 4'b0000;
        TSel   = (idx < 4)  ? (4'b1000 >> idx)       : 4'b0000;
        tick();
        RSel = 4'b0000;
        TSel = 4'b0000;
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 8; i++) begin
            O1Sel = 3'(i);
            O2Sel = 3'(7 - i);
            #1;
            vectors++;
            if (O1 !== 8'h00 || O2 !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_init sel=%0d O1=%h O2=%h expected 00", i, O1, O2);
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        FunSel = 2'b01;
        I      = 8'h14;
        RSel   = 4'b1111;
        TSel   = 4'b1111;
        tick();
        O1Sel = 3'b100;
        O2Sel = 3'b011;
        #1;
        vectors++;
        if (O1 !== 8'h14 || O2 !== 8'h14) begin
            miscompares++;
            $display("FAIL reset_preload O1=%h O2=%h expected 14", O1, O2);
        end
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            O1Sel = 3'(i);
            O2Sel = 3'(7 - i);
            #1;
            vectors++;
            if (O1 !== 8'h00 || O2 !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_async sel=%0d O1=%h O2=%h expected 00", i, O1, O2);
            end
        end
        repeat (2) begin
            tick();
            vectors++;
            if (O1 !== 8'h00 || O2 !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_held O1=%h O2=%h expected 00", O1, O2);
            end
        end
        @(negedge clock);
        RSel    = 4'b0000;
        TSel    = 4'b0000;
        reset_n = 1'b1;
    endtask

    task automatic test_load_map();
        @(negedge clock);
        FunSel = 2'b01;
        I      = 8'h14;
        RSel   = 4'b1000;
        TSel   = 4'b1000;
        tick();
        RSel = 4'b0000;
        TSel = 4'b0000;
        O1Sel = 3'b100;
        O2Sel = 3'b000;
        #1;
        vectors++;
        if (O1 !== 8'h14 || O2 !== 8'h14) begin
            miscompares++;
            $display("FAIL load_r1_t1 O1=%h O2=%h expected 14", O1, O2);
        end
        O1Sel = 3'b101;
        O2Sel = 3'b001;
        #1;
        vectors++;
        if (O1 !== 8'h00 || O2 !== 8'h00) begin
            miscompares++;
            $display("FAIL load_r2_t2 O1=%h O2=%h expected 00", O1, O2);
        end
        O1Sel = 3'b100;
        O2Sel = 3'b000;
    endtask

    task automatic test_inc_dec();
        @(negedge clock);
        FunSel = 2'b11;
        RSel   = 4'b1000;
        TSel   = 4'b1000;
        repeat (2) tick();
        vectors++;
        if (O1 !== 8'h16 || O2 !== 8'h16) begin
            miscompares++;
            $display("FAIL inc2 O1=%h O2=%h expected 16", O1, O2);
        end
        @(negedge clock);
        FunSel = 2'b10;
        repeat (3) tick();
        vectors++;
        if (O1 !== 8'h13 || O2 !== 8'h13) begin
            miscompares++;
            $display("FAIL dec3 O1=%h O2=%h expected 13", O1, O2);
        end
        @(negedge clock);
        FunSel = 2'b11;
        RSel   = 4'b0000;
        TSel   = 4'b0000;
        repeat (2) tick();
        vectors++;
        if (O1 !== 8'h13 || O2 !== 8'h13) begin
            miscompares++;
            $display("FAIL hold_unselected O1=%h O2=%h expected 13", O1, O2);
        end
    endtask

    task automatic test_wrap();
        load_one(7, 8'hFF);
        load_one(3, 8'h00);
        @(negedge clock);
        FunSel = 2'b11;
        RSel   = 4'b0001;
        tick();
        RSel  = 4'b0000;
        O1Sel = 3'b111;
        #1;
        vectors++;
        if (O1 !== c_EXP_INC_FF) begin
            miscompares++;
            $display("FAIL inc_ff R4=%h expected %h", O1, c_EXP_INC_FF);
        end
        @(negedge clock);
        FunSel = 2'b10;
        TSel   = 4'b0001;
        tick();
        TSel  = 4'b0000;
        O2Sel = 3'b011;
        #1;
        vectors++;
        if (O2 !== c_EXP_DEC_00) begin
            miscompares++;
            $display("FAIL dec_00 T4=%h expected %h", O2, c_EXP_DEC_00);
        end
    endtask

    task automatic test_clear_multi();
        logic [7:0] exp_v [8];
        exp_v = '{8'h00, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h00};
        @(negedge clock);
        FunSel = 2'b01;
        I      = 8'hA5;
        RSel   = 4'b1111;
        TSel   = 4'b1111;
        tick();
        @(negedge clock);
        FunSel = 2'b00;
        RSel   = 4'b0101;
        TSel   = 4'b1010;
        tick();
        RSel = 4'b0000;
        TSel = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            O1Sel = 3'(i);
            O2Sel = 3'(7 - i);
            #0.5;
            vectors++;
            if (O1 !== exp_v[i] || O2 !== exp_v[7 - i]) begin
                miscompares++;
                $display("FAIL clear_multi sel=%0d O1=%h exp %h O2=%h exp %h",
                         i, O1, exp_v[i], O2, exp_v[7 - i]);
            end
        end
    endtask

    task automatic test_read_indep();
        for (int k = 0; k < 8; k++) load_one(k, 8'h30 + 8'(k));
        @(negedge clock);
        clk_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            O1Sel = 3'(i);
            O2Sel = 3'((i + 3) % 8);
            #1;
            vectors++;
            if (O1 !== 8'h30 + 8'(i) || O2 !== 8'h30 + 8'((i + 3) % 8)) begin
                miscompares++;
                $display("FAIL read_mux sel=%0d O1=%h O2=%h", i, O1, O2);
            end
        end
        O1Sel  = 3'b110;
        O2Sel  = 3'b110;
        FunSel = 2'b11;
        RSel   = 4'b1111;
        TSel   = 4'b1111;
        #3;
        FunSel = 2'b00;
        #3;
        vectors++;
        if (O1 !== 8'h36 || O2 !== 8'h36) begin
            miscompares++;
            $display("FAIL no_edge_hold O1=%h O2=%h expected 36", O1, O2);
        end
        RSel   = 4'b0000;
        TSel   = 4'b0000;
        clk_en = 1'b1;
        tick();
        vectors++;
        if (O1 !== 8'h36) begin
            miscompares++;
            $display("FAIL restart_hold O1=%h expected 36", O1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clock   = 1'b0;
        clk_en  = 1'b1;
        reset_n = 1'b0;
        O1Sel   = 3'b000;
        O2Sel   = 3'b000;
        FunSel  = 2'b01;
        RSel    = 4'b0000;
        TSel    = 4'b0000;
        I       = 8'h14;

        test_reset();
        test_load_map();
        test_inc_dec();
        test_wrap();
        test_clear_multi();
        test_read_indep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- 8-register datapath storage block: four general-purpose registers R1..R4 and four temporary registers T1..T4, all WIDTH bits.
- Each register independently clears, loads, increments or decrements under one shared 2-bit function code, gated by per-register select bits.
- Two independent combinational read ports, O1 and O2, each able to view any of the eight registers.
- Sits in the CPU datapath between the ALU/memory input bus (I) and the ALU operand inputs.

Parameters:
- WIDTH, 8, data width of every register, the input bus and both outputs.

Ports:
- clock  input  1  single clock; all register updates occur on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- O1Sel  input  3  read-port-1 source select.
- O2Sel  input  3  read-port-2 source select.
- FunSel  input  2  function applied to every selected register.
- RSel  input  4  general-register enables; bit3=R1, bit2=R2, bit1=R3, bit0=R4.
- TSel  input  4  temp-register enables; bit3=T1, bit2=T2, bit1=T3, bit0=T4.
- I  input  WIDTH  load data bus.
- O1  output  WIDTH  read port 1 data.
- O2  output  WIDTH  read port 2 data.

Behaviour:
- Reset:
  - reset_n low asynchronously forces all eight registers to 0, so O1=O2=0 immediately.
  - Reset dominates clock, FunSel and selects.
  - Registers stay 0 while reset_n is low.
  - The first update occurs on the first rising clock edge after reset_n is high.
- Per-register update on each rising clock edge, when that register's select bit is 1:
  - FunSel 00: clear, reg <= 0.
  - FunSel 01: load, reg <= I.
  - FunSel 10: decrement, reg <= reg - 1, modulo 2^WIDTH (00 -> FF).
  - FunSel 11: increment, reg <= reg + 1, modulo 2^WIDTH (FF -> 00).
- A register whose select bit is 0 holds its value regardless of FunSel.
- Any combination of RSel/TSel bits may be active at once; all selected registers apply the same FunSel in the same cycle. All-zero selects means no register changes.
- Read mux, identical for O1Sel and O2Sel:
  - 000=T1, 001=T2, 010=T3, 011=T4.
  - 100=R1, 101=R2, 110=R3, 111=R4.
- Reads are purely combinational from current register state.
  - A write is visible on O1/O2 only after the clock edge that performs it; there is no write-through bypass.
  - Both ports may select the same register simultaneously.
- Latency: 1 clock for any update; 0 clocks for read select changes.
- Outputs are never X after reset; all eight registers are always defined.
- Structure: one reusable WIDTH-bit register submodule with enable, FunSel, I and async reset, instantiated eight times, plus two 8:1 muxes.

Optional Feature:
- Macro RF_SATURATE_EN.
- When defined:
  - Increment of all-ones holds at all-ones (FF stays FF).
  - Decrement of 0 holds at 0.
  - All other operations are unchanged.
- When undefined: increment and decrement wrap modulo 2^WIDTH as described above.

Test Plan:
- Reset: drive I=8'h14, RSel=4'b1111, TSel=4'b1111, FunSel=01, assert reset_n low mid-cycle -> O1/O2 read 0 for every O1Sel/O2Sel value immediately and across clock edges while reset_n is low.
- Load/read mapping: FunSel=01, RSel=1000, TSel=1000, I=8'h14, one edge -> O1Sel=100 gives O1=8'h14 and O2Sel=000 gives O2=8'h14; O1Sel=101 and O2Sel=001 give 0.
- Increment/decrement: from R1=T1=8'h14, FunSel=11 for 2 edges -> both read 8'h16; FunSel=10 for 3 edges -> both read 8'h13; RSel=TSel=0000 with FunSel=11 for 2 edges -> both stay 8'h13.
- Wrap/saturation:
  - R4 loaded with 8'hFF, FunSel=11, one edge -> R4=8'h00 without RF_SATURATE_EN, 8'hFF with it.
  - T4=0, FunSel=10, one edge -> T4=8'hFF without the macro, 8'h00 with it.
- Clear and multi-select: load all eight registers with 8'hA5, then FunSel=00, RSel=0101, TSel=1010 -> R2, R4, T1, T3 read 0; R1, R3, T2, T4 read 8'hA5.
- Read independence: change O1Sel/O2Sel with clock stopped -> outputs track selected registers combinationally; a FunSel change without a clock edge leaves all outputs unchanged.
